// File: rtl/bus_arbiter_8_to_1_16_bit_pkg.sv
// Shared constants, state encoding and helpers for the 8-to-1 bus arbiter.
package bus_arbiter_8_to_1_16_bit_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot grant vector for requester index i.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/bus_arbiter_8_to_1_16_bit_mux.sv
// 8:1 16-bit datapath multiplexer.
//   d0..d7 : data inputs
//   s      : 3-bit select (S2..S0)
//   y      : selected word
module mux_8_to_1_16
  import bus_arbiter_8_to_1_16_bit_pkg::*;
(
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [DATA_W-1:0] d4,
  input  logic [DATA_W-1:0] d5,
  input  logic [DATA_W-1:0] d6,
  input  logic [DATA_W-1:0] d7,
  input  logic [SEL_W-1:0]  s,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    unique case (s)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      default: y = d7;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_8_to_1_16_bit_rr_pick_8.sv
// Round-robin picker: finds the first set bit of mask searching from last+1
// upward, wrapping modulo 8.
//   mask : candidate requesters
//   last : index most recently served (lowest priority this round)
//   any  : at least one candidate present
//   win  : index of the winning candidate (valid when any=1)
module rr_pick_8
  import bus_arbiter_8_to_1_16_bit_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0]     start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     idx;

  // Rotate so that requester last+1 lands at bit 0; the lowest set bit of the
  // rotated mask is then the round-robin winner, offset back by start.
  assign start = last + 3'd1;
  assign dbl   = {mask, mask} >> start;
  assign rot   = dbl[NUM_REQ-1:0];
  assign any   = |mask;

  always_comb begin
    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
  end

  assign win = idx + start;

endmodule

// File: rtl/bus_arbiter_8_to_1_16_bit.sv
// Round-robin arbiter sharing one 16-bit output bus among 8 requesters, with
// locked bursts capped at MAX_BEATS consecutive beats.
//   clk, rst_n : clock, synchronous active-low reset
//   req, lock  : per-requester request and burst-lock
//   I0..I7     : requester data words
//   out_data   : I[sel] (combinational)
//   out_valid  : registered; a word is presented
//   out_ready  : consumer accepts; transfer = out_valid & out_ready
//   gnt, sel   : registered one-hot grant and its index
//   ack        : per-requester pulse on each transferred beat
module bus_arbiter_8_to_1_16_bit
  import bus_arbiter_8_to_1_16_bit_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic [DATA_W-1:0]  I0,
  input  logic [DATA_W-1:0]  I1,
  input  logic [DATA_W-1:0]  I2,
  input  logic [DATA_W-1:0]  I3,
  input  logic [DATA_W-1:0]  I4,
  input  logic [DATA_W-1:0]  I5,
  input  logic [DATA_W-1:0]  I6,
  input  logic [DATA_W-1:0]  I7,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] ack
);

  state_e             state;
  logic [SEL_W-1:0]   last;
  logic [3:0]         beat_cnt;

  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   pick_last;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_win;
  logic               xfer;
  logic               cont;

  assign xfer = out_valid & out_ready;
  assign cont = lock[sel] & req[sel] & (beat_cnt < 4'(MAX_BEATS));
  assign ack  = gnt & {NUM_REQ{xfer}};

  // When re-arbitrating after a beat, the current holder is excluded and the
  // search starts just after it, so a requester that re-raises req right after
  // its ack waits a full round.
  always_comb begin
    pick_mask = req;
    pick_last = last;
    if (state == GRANT) begin
      pick_mask = req & ~gnt;
      pick_last = sel;
    end
  end

  rr_pick_8 u_pick (
    .mask (pick_mask),
    .last (pick_last),
    .any  (pick_any),
    .win  (pick_win)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
      last      <= 3'd7;
    end else if (state == IDLE) begin
      if (pick_any) begin
        state     <= GRANT;
        gnt       <= onehot(pick_win);
        sel       <= pick_win;
        out_valid <= 1'b1;
        beat_cnt  <= 4'd1;
      end
    end else if (xfer) begin
      if (cont) begin
        beat_cnt <= beat_cnt + 4'd1;
      end else begin
        last <= sel;
        if (pick_any) begin
          gnt      <= onehot(pick_win);
          sel      <= pick_win;
          beat_cnt <= 4'd1;
        end else begin
          state     <= IDLE;
          gnt       <= '0;
          out_valid <= 1'b0;
          beat_cnt  <= '0;
        end
      end
    end
  end

  mux_8_to_1_16 u_mux (
    .d0 (I0), .d1 (I1), .d2 (I2), .d3 (I3),
    .d4 (I4), .d5 (I5), .d6 (I6), .d7 (I7),
    .s  (sel),
    .y  (out_data)
  );

endmodule

// File: tb/tb_bus_arbiter_8_to_1_16_bit.sv
module tb_bus_arbiter_8_to_1_16_bit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  lock;
  logic [15:0] din [8];
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic [7:0]  ack;

  int n_checks = 0;
  int n_errors = 0;

  // Expected winner index of each transferred beat, in order.
  logic [2:0] sb [$];

  bus_arbiter_8_to_1_16_bit #(.MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .I0        (din[0]),
    .I1        (din[1]),
    .I2        (din[2]),
    .I3        (din[3]),
    .I4        (din[4]),
    .I5        (din[5]),
    .I6        (din[6]),
    .I7        (din[7]),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = '0;
    lock      = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: every transferred beat must match the head of the scoreboard.
  initial begin
    logic [2:0] idx;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("mon_unexpected_beat", {29'd0, sel}, 32'hFFFF_FFFF);
        end else begin
          idx = sb.pop_front();
          check("mon_sel",  {29'd0, sel}, {29'd0, idx});
          check("mon_gnt",  {24'd0, gnt}, {24'd0, 8'(1) << idx});
          check("mon_ack",  {24'd0, ack}, {24'd0, 8'(1) << idx});
          check("mon_data", {16'd0, out_data}, {16'd0, din[idx]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    din[0] = 16'hA5A5;
    for (int i = 1; i < 8; i++) din[i] = 16'(i) * 16'h1111;

    // 1. Reset then single request
    apply_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_gnt",   {24'd0, gnt}, 32'd0);
    check("rst_sel",   {29'd0, sel}, 32'd0);
    sb.push_back(3'd0);
    req = 8'h01; out_ready = 1'b1;
    step();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_gnt",   {24'd0, gnt}, 32'h01);
    check("t1_data",  {16'd0, out_data}, 32'hA5A5);
    check("t1_ack",   {24'd0, ack}, 32'h01);
    req = 8'h00;
    step();
    check("t1_idle_valid", {31'd0, out_valid}, 32'd0);
    check("t1_idle_gnt",   {24'd0, gnt}, 32'd0);
    check("t1_sb_empty", sb.size(), 32'd0);

    // 2. Round-robin fairness, no bubbles, wrap 7 -> 0
    apply_reset();
    for (int i = 0; i < 10; i++) sb.push_back(3'(i % 8));
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_no_bubble", {31'd0, out_valid}, 32'd1);
    end
    req = 8'h00;
    step();
    check("t2_idle", {31'd0, out_valid}, 32'd0);
    check("t2_sb_empty", sb.size(), 32'd0);

    // 3. Backpressure
    apply_reset();
    req = 8'h24; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_gnt",  {24'd0, gnt}, 32'h04);
      check("t3_hold_sel",  {29'd0, sel}, 32'd2);
      check("t3_hold_data", {16'd0, out_data}, {16'd0, din[2]});
      check("t3_hold_ack",  {24'd0, ack}, 32'd0);
    end
    sb.push_back(3'd2);
    sb.push_back(3'd5);
    out_ready = 1'b1;
    #1;
    check("t3_ack", {24'd0, ack}, 32'h04);
    step();
    check("t3_next_gnt", {24'd0, gnt}, 32'h20);
    req = 8'h00;
    step();
    check("t3_idle", {31'd0, out_valid}, 32'd0);
    check("t3_sb_empty", sb.size(), 32'd0);

    // 4. Locked burst capped at 4 beats
    apply_reset();
    sb.push_back(3'd0); sb.push_back(3'd0); sb.push_back(3'd0); sb.push_back(3'd0);
    sb.push_back(3'd1); sb.push_back(3'd0);
    req = 8'h03; lock = 8'h01; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    req = 8'h00; lock = 8'h00;
    step();
    check("t4_idle", {31'd0, out_valid}, 32'd0);
    check("t4_sb_empty", sb.size(), 32'd0);

    // 5. Requester 3 re-requests on its ack while 6 requests: 6 goes first
    apply_reset();
    sb.push_back(3'd3); sb.push_back(3'd6); sb.push_back(3'd3);
    req = 8'h08; out_ready = 1'b1;
    step();
    req = 8'h48;
    step();
    check("t5_gnt6", {24'd0, gnt}, 32'h40);
    step();
    req = 8'h00;
    step();
    check("t5_idle", {31'd0, out_valid}, 32'd0);
    check("t5_sb_empty", sb.size(), 32'd0);

    // 6. Reset mid-burst, then requester 0 wins first
    apply_reset();
    req = 8'h10; out_ready = 1'b0;
    step();
    check("t6_gnt_pre", {24'd0, gnt}, 32'h10);
    rst_n = 1'b0;
    step();
    check("t6_rst_gnt",   {24'd0, gnt}, 32'd0);
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_sel",   {29'd0, sel}, 32'd0);
    check("t6_rst_ack",   {24'd0, ack}, 32'd0);
    sb.push_back(3'd0); sb.push_back(3'd4);
    rst_n = 1'b1; req = 8'h11; out_ready = 1'b1;
    step();
    check("t6_first_gnt", {24'd0, gnt}, 32'h01);
    step();
    req = 8'h00;
    step();
    check("t6_idle", {31'd0, out_valid}, 32'd0);
    check("t6_sb_empty", sb.size(), 32'd0);

    // 7. Lone requester holding req: excluded on re-arbitration, so IDLE between beats
    apply_reset();
    sb.push_back(3'd0); sb.push_back(3'd0);
    req = 8'h01; out_ready = 1'b1;
    step();
    check("t7_v1", {31'd0, out_valid}, 32'd1);
    step();
    check("t7_v2", {31'd0, out_valid}, 32'd0);
    step();
    check("t7_v3", {31'd0, out_valid}, 32'd1);
    req = 8'h00;
    step();
    check("t7_v4", {31'd0, out_valid}, 32'd0);
    check("t7_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_8_to_1_16_bit.md
Name: bus_arbiter_8_to_1_16_bit

Overview:
- Round-robin arbiter that shares one 16-bit output bus between 8 requesters.
- Drives the 3-bit select of an 8:1 16-bit datapath mux and presents the selected word on a valid/ready output handshake.
- Supports locked bursts, capped by a beat counter so that no requester starves the others.
- Sits between the write-back sources and the single shared result/write bus.

Parameters:
- MAX_BEATS, 4: maximum consecutive transfers one locked requester may hold the grant (1..15).
- DATA_W, 16: bus width; fixed at 16 for this design.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  8  req[i]=1: requester i has a word on Ii.
- lock  in  8  lock[i]=1 with req[i]: requester i requests to keep the grant after its current beat.
- I0..I7  in  16 each  requester data words.
- out_data  out  16  selected word, combinational from sel.
- out_valid  out  1  registered; a word is presented.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid & out_ready.
- gnt  out  8  registered one-hot grant (all zero when idle).
- sel  out  3  registered index of the granted requester; equals the mux S2..S0.
- ack  out  8  combinational gnt & {8{out_ready & out_valid}}; one pulse per transferred beat.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n=0 at an edge): state=IDLE, gnt=0, sel=0, out_valid=0, beat_cnt=0, last=7. Because last=7, the first arbitration favours requester 0.
- Reset mid-transfer: state is dropped immediately and no ack is produced after the reset edge.
- States: IDLE and GRANT.
- Round-robin pick: search order is last+1, last+2, ... wrapping modulo 8. The first requester set in the candidate mask wins.
- IDLE:
  - If req != 0, pick using mask=req.
  - Next edge: state=GRANT, gnt=onehot(w), sel=w, out_valid=1, beat_cnt=1.
  - Latency is one cycle from req to out_valid.
- GRANT, no transfer (out_ready=0): gnt, sel and out_valid hold.
  - The requester must hold req and Ii stable until it sees ack.
  - The arbiter ignores a req drop in this state and keeps presenting.
- GRANT, transfer cycle. Let g = sel.
  - Continue the burst if lock[g] & req[g] & (beat_cnt < MAX_BEATS). Then gnt and sel hold, beat_cnt increments, out_valid stays 1, and last is not updated.
  - Otherwise, set last=g and re-arbitrate in the same cycle with mask = req & ~gnt.
    - If mask != 0, the new winner is granted at the next edge with beat_cnt=1 (back-to-back, no bubble).
    - If mask == 0, next state is IDLE and out_valid=0.
  - A requester that sees ack and still has req high because of a new word must wait for the next round. The only exception is continuation under lock.
- MAX_BEATS cap: when beat_cnt reaches MAX_BEATS, the burst is forcibly broken even if lock stays high. The locked requester re-enters normal rotation as lowest priority.
- out_data = I[sel] at all times; its value is don't-care when out_valid=0.
- Invariants:
  - gnt is zero or one-hot.
  - gnt != 0 iff out_valid.
  - sel == index(gnt) whenever out_valid.
  - ack has at most one bit set.

Decomposition:
- Shared package constants: NUM_REQ=8, SEL_W=3, DATA_W=16; state encoding IDLE=1'b0, GRANT=1'b1.
- Sub-module rr_pick_8 (combinational): inputs mask[7:0] and last[2:0]; outputs any and win[2:0]. Implement as rotate, priority-encode, then add last+1 modulo 8.
- Data selection instantiates the team's 8:1 16-bit mux with S2..S0 = sel.

Test Plan:
1. Reset then single request: rst_n=0 for 2 cycles; then req=8'h01, I0=16'hA5A5, out_ready=1 → one cycle later out_valid=1, gnt=8'h01, sel=0, out_data=16'hA5A5, ack[0] pulses; with req low afterwards, IDLE next cycle.
2. Round-robin fairness: req=8'hFF held, out_ready=1, lock=0 → grant order 0,1,2,...,7,0; one transfer per cycle with no bubbles; last wraps from 7 to 0.
3. Backpressure: req=8'h24, out_ready=0 for 5 cycles → gnt=8'h04 and sel=2 stable, out_data=I2, ack=0; out_ready=1 → ack=8'h04, then gnt=8'h20 next cycle.
4. Locked burst cap: MAX_BEATS=4, req=8'h03, lock=8'h01, out_ready=1 → requester 0 gets 4 consecutive beats, requester 1 gets the 5th beat, then requester 0 again.
5. Simultaneous events: requester 3 sees ack and re-asserts req in the same cycle while requester 6 requests → requester 6 is granted before requester 3.
6. Reset mid-burst: rst_n=0 while gnt=8'h10 and out_valid=1 → next edge gnt=0, out_valid=0, sel=0; after release with req=8'h11, requester 0 wins first.
